// File: rtl/ex_stage_pipe.sv
// Execute stage: single-cycle ALU and branch resolution, plus an
// iterative multiply/divide unit behind a one-entry output register.
module ex_stage_pipe #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      alu_op_i,
  input  logic [1:0]      data_origin_i,
  input  logic            br_sig_i,
  input  logic [2:0]      br_op_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_result_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] new_pc_o,
  output logic            br_taken_o,
  output logic            illegal_o
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [SW-1:0]   cnt;
  logic [2:0]      md_op;
  logic [XLEN-1:0] acc, aq, bq, dvd_q, mpc4_q;
  logic            neg_q, div0_q;

  logic [XLEN-1:0] op_a, op_b, sum, alu_res, npc, pc4;
  logic [SW-1:0]   shamt;
  logic            is_md, legal, sc_ok, cond, taken, accept;
  logic            sa, sb, sgn;

  assign pc4    = pc_i + XLEN'(4);
  assign in_ready_o = rst_n & (state == IDLE) &
                      (!out_valid_o | out_ready_i) & !flush_i;
  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    op_a    = data_origin_i[0] ? pc_i : rs1_i;
    op_b    = data_origin_i[1] ? imm_i : rs2_i;
    sum     = op_a + op_b;
    shamt   = op_b[SW-1:0];
    is_md   = 1'b0;
    legal   = 1'b1;
    alu_res = '0;
    case (alu_op_i)
      5'd0:  alu_res = sum;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a << shamt;
      5'd3:  alu_res = {{(XLEN-1){1'b0}},
                        $signed(op_a) < $signed(op_b)};
      5'd4:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      5'd5:  alu_res = op_a ^ op_b;
      5'd6:  alu_res = op_a >> shamt;
      5'd7:  alu_res = $signed(op_a) >>> shamt;
      5'd8:  alu_res = op_a | op_b;
      5'd9:  alu_res = op_a & op_b;
      5'd10: alu_res = op_b;
      5'd16, 5'd17, 5'd18, 5'd19, 5'd20: begin
        is_md = 1'b1;
        legal = MULDIV_EN;
      end
      default: legal = 1'b0;
    endcase
  end

  // Branch compare is always rs1 vs rs2, whatever feeds the ALU.
  always_comb begin
    cond = 1'b1;
    unique case (1'b1)
      br_op_i == 3'b000: cond = rs1_i == rs2_i;
      br_op_i == 3'b001: cond = rs1_i != rs2_i;
      br_op_i == 3'b100: cond = $signed(rs1_i) < $signed(rs2_i);
      br_op_i == 3'b101: cond = $signed(rs1_i) >= $signed(rs2_i);
      br_op_i == 3'b110: cond = rs1_i < rs2_i;
      br_op_i == 3'b111: cond = rs1_i >= rs2_i;
      default:           cond = 1'b1;
    endcase
    sc_ok = legal & !is_md;
    taken = br_sig_i & sc_ok & cond;
    if (br_sig_i && sc_ok && br_op_i == 3'b011)
      npc = sum & {{(XLEN-1){1'b1}}, 1'b0};
    else if (taken)
      npc = pc_i + imm_i;
    else
      npc = pc4;
  end

  assign sgn = (alu_op_i == 5'd17) | (alu_op_i == 5'd19);
  assign sa  = sgn & op_a[XLEN-1];
  assign sb  = sgn & op_b[XLEN-1];

  logic [XLEN:0]   rem_try, rem_diff;
  logic            ge;
  logic [XLEN-1:0] acc_n, aq_n, bq_n, md_res;

  // One multiply or restoring-divide step per cycle.
  always_comb begin
    rem_try  = {acc, aq[XLEN-1]};
    rem_diff = rem_try - {1'b0, bq};
    ge       = rem_try >= {1'b0, bq};
    if (md_op == 3'd0) begin
      acc_n = aq[0] ? acc + bq : acc;
      aq_n  = aq >> 1;
      bq_n  = bq << 1;
    end else begin
      acc_n = ge ? rem_diff[XLEN-1:0] : rem_try[XLEN-1:0];
      aq_n  = {aq[XLEN-2:0], ge};
      bq_n  = bq;
    end
    case (md_op)
      3'd0:       md_res = acc_n;
      3'd1, 3'd2: md_res = div0_q ? '1 : (neg_q ? -aq_n : aq_n);
      3'd3, 3'd4: md_res = div0_q ? dvd_q : (neg_q ? -acc_n : acc_n);
      default:    md_res = acc_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      md_op        <= '0;
      acc          <= '0;
      aq           <= '0;
      bq           <= '0;
      dvd_q        <= '0;
      mpc4_q       <= '0;
      neg_q        <= 1'b0;
      div0_q       <= 1'b0;
      out_valid_o  <= 1'b0;
      alu_result_o <= '0;
      pc_plus4_o   <= '0;
      new_pc_o     <= '0;
      br_taken_o   <= 1'b0;
      illegal_o    <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      state       <= IDLE;
    end else begin
      if (out_valid_o && out_ready_i)
        out_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_md && MULDIV_EN) begin
            state  <= BUSY;
            cnt    <= '0;
            md_op  <= alu_op_i[2:0];
            acc    <= '0;
            aq     <= sa ? -op_a : op_a;
            bq     <= sb ? -op_b : op_b;
            neg_q  <= (alu_op_i == 5'd17) ? (sa ^ sb) :
                      (alu_op_i == 5'd19) ? sa : 1'b0;
            div0_q <= op_b == '0;
            dvd_q  <= op_a;
            mpc4_q <= pc4;
          end else if (accept) begin
            out_valid_o  <= 1'b1;
            alu_result_o <= alu_res;
            pc_plus4_o   <= pc4;
            new_pc_o     <= npc;
            br_taken_o   <= taken;
            illegal_o    <= !legal;
          end
        end
        BUSY: begin
          acc <= acc_n;
          aq  <= aq_n;
          bq  <= bq_n;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(XLEN-1)) begin
            state        <= IDLE;
            out_valid_o  <= 1'b1;
            alu_result_o <= md_res;
            pc_plus4_o   <= mpc4_q;
            new_pc_o     <= mpc4_q;
            br_taken_o   <= 1'b0;
            illegal_o    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe (XLEN=32, MULDIV_EN=1).
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b1;
  logic        br_sig_i = 1'b0;
  logic [31:0] pc_i = '0, rs1_i = '0, rs2_i = '0, imm_i = '0;
  logic [4:0]  alu_op_i = '0;
  logic [1:0]  data_origin_i = '0;
  logic [2:0]  br_op_i = '0;
  logic        in_ready_o, out_valid_o, br_taken_o, illegal_o;
  logic [31:0] alu_result_o, pc_plus4_o, new_pc_o;

  ex_stage_pipe #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .alu_op_i(alu_op_i), .data_origin_i(data_origin_i),
    .br_sig_i(br_sig_i), .br_op_i(br_op_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_result_o(alu_result_o), .pc_plus4_o(pc_plus4_o),
    .new_pc_o(new_pc_o), .br_taken_o(br_taken_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res, pc4, npc;
    logic        tk, ill;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    logic [31:0] a, b;
    logic sc, cond;
    int sa, sb;
    a = data_origin_i[0] ? pc_i : rs1_i;
    b = data_origin_i[1] ? imm_i : rs2_i;
    sa = a;
    sb = b;
    sc = 1'b1;
    e = '0;
    case (alu_op_i)
      5'd0:  e.res = a + b;
      5'd1:  e.res = a - b;
      5'd2:  e.res = a << b[4:0];
      5'd3:  e.res = {31'b0, sa < sb};
      5'd4:  e.res = {31'b0, a < b};
      5'd5:  e.res = a ^ b;
      5'd6:  e.res = a >> b[4:0];
      5'd7:  e.res = 32'(sa >>> b[4:0]);
      5'd8:  e.res = a | b;
      5'd9:  e.res = a & b;
      5'd10: e.res = b;
      5'd16: begin sc = 1'b0; e.res = a * b; end
      5'd17: begin
        sc = 1'b0;
        if (b == 0) e.res = '1;
        else if (a == 32'h8000_0000 && b == '1) e.res = a;
        else e.res = 32'(sa / sb);
      end
      5'd18: begin sc = 1'b0; e.res = (b == 0) ? '1 : a / b; end
      5'd19: begin
        sc = 1'b0;
        if (b == 0) e.res = a;
        else if (a == 32'h8000_0000 && b == '1) e.res = '0;
        else e.res = 32'(sa % sb);
      end
      5'd20: begin sc = 1'b0; e.res = (b == 0) ? a : a % b; end
      default: begin sc = 1'b0; e.ill = 1'b1; end
    endcase
    case (br_op_i)
      3'b000:  cond = rs1_i == rs2_i;
      3'b001:  cond = rs1_i != rs2_i;
      3'b100:  cond = $signed(rs1_i) < $signed(rs2_i);
      3'b101:  cond = $signed(rs1_i) >= $signed(rs2_i);
      3'b110:  cond = rs1_i < rs2_i;
      3'b111:  cond = rs1_i >= rs2_i;
      default: cond = 1'b1;
    endcase
    e.tk  = br_sig_i & sc & cond;
    e.pc4 = pc_i + 32'd4;
    if (br_sig_i && sc && br_op_i == 3'b011)
      e.npc = (a + b) & ~32'd1;
    else if (e.tk)
      e.npc = pc_i + imm_i;
    else
      e.npc = pc_i + 32'd4;
    return e;
  endfunction

  task automatic send(input logic [4:0] op, input logic [1:0] org,
                      input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] im,
                      input logic bs, input logic [2:0] bo,
                      input bit push);
    int n;
    alu_op_i = op;
    data_origin_i = org;
    pc_i = pc;
    rs1_i = r1;
    rs2_i = r2;
    imm_i = im;
    br_sig_i = bs;
    br_op_i = bo;
    in_valid_i = 1'b1;
    #2;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    else if (push) sbq.push_back(model());
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic md_run(input logic [4:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] exp,
                        input string tag);
    int busy;
    send(op, 2'b00, 32'h500, r1, r2, 32'h0, 1'b0, 3'b000, 1'b1);
    #1;
    busy = 0;
    for (int c = 0; c < 100 && !out_valid_o; c++) begin
      if (!in_ready_o) busy++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_busy"}, busy, 32);
    chk({tag, "_res"}, alu_result_o, exp);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_res", alu_result_o, e.res);
        chk("sb_pc4", pc_plus4_o, e.pc4);
        chk("sb_npc", new_pc_o, e.npc);
        chk("sb_taken", br_taken_o, e.tk);
        chk("sb_illegal", illegal_o, e.ill);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 0);
    chk("rst_res", alu_result_o, 0);
    chk("rst_npc", new_pc_o, 0);
    chk("rst_pc4", pc_plus4_o, 0);
    chk("rst_taken", br_taken_o, 0);
    chk("rst_illegal", illegal_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(5'd0, 2'b00, 32'h40, 32'd5, 32'd7, 32'd0, 1'b0, 3'b000, 1'b1);
    #1;
    chk("add_lat", out_valid_o, 1);
    chk("add_res", alu_result_o, 12);
    chk("add_pc4", pc_plus4_o, 32'h44);

    send(5'd0, 2'b00, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20,
         1'b1, 3'b100, 1'b1);
    #1;
    chk("blt_taken", br_taken_o, 1);
    chk("blt_npc", new_pc_o, 32'h120);
    send(5'd0, 2'b00, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20,
         1'b1, 3'b110, 1'b1);
    #1;
    chk("bltu_taken", br_taken_o, 0);
    chk("bltu_npc", new_pc_o, 32'h104);
    send(5'd0, 2'b10, 32'h300, 32'h203, 32'd0, 32'd4,
         1'b1, 3'b011, 1'b1);
    #1;
    chk("jalr_taken", br_taken_o, 1);
    chk("jalr_npc", new_pc_o, 32'h206);

    for (int i = 0; i < 11; i++)
      send(5'(i), 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom, $urandom, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'b1);
    send(5'd2, 2'b00, 32'h0, 32'h1, 32'd31, 32'h0, 1'b0, 3'b0, 1'b1);
    send(5'd7, 2'b10, 32'h0, 32'h8000_0000, 32'h0, 32'd36,
         1'b0, 3'b0, 1'b1);
    send(5'd3, 2'b00, 32'h0, 32'h8000_0000, 32'd1, 32'h0,
         1'b0, 3'b0, 1'b1);
    send(5'd11, 2'b00, 32'h80, 32'd1, 32'd2, 32'h0, 1'b1, 3'b010, 1'b1);
    #1;
    chk("illegal_flag", illegal_o, 1);
    chk("illegal_taken", br_taken_o, 0);
    send(5'd25, 2'b00, 32'h90, 32'd1, 32'd2, 32'h0, 1'b0, 3'b0, 1'b1);

    md_run(5'd17, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
    md_run(5'd19, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
    md_run(5'd18, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu0");
    md_run(5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divovf");
    md_run(5'd19, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "removf");
    md_run(5'd20, 32'd9, 32'd0, 32'd9, "remu0");
    md_run(5'd16, 32'd3, 32'd4, 32'd12, "mul");
    md_run(5'd16, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, "mulneg");
    md_run(5'd18, 32'hDEAD_BEEF, 32'd1000, 32'hDEAD_BEEF / 32'd1000,
           "divu");

    @(negedge clk);
    out_ready_i = 1'b0;
    fork
      begin
        send(5'd0, 2'b00, 32'h10, 32'd1, 32'd2, 32'd0, 1'b0, 3'b0, 1'b1);
        send(5'd1, 2'b00, 32'h14, 32'd9, 32'd4, 32'd0, 1'b0, 3'b0, 1'b1);
        send(5'd5, 2'b00, 32'h18, 32'hF0, 32'hFF, 32'd0, 1'b0, 3'b0,
             1'b1);
      end
      begin
        repeat (6) @(negedge clk);
        #1;
        chk("bp_hold_valid", out_valid_o, 1);
        chk("bp_hold_res", alu_result_o, 3);
        chk("bp_ready_low", in_ready_o, 0);
        @(negedge clk);
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("bp_stream", out_valid_o, 1);
          @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);

    send(5'd16, 2'b00, 32'h0, 32'd3, 32'd4, 32'd0, 1'b0, 3'b0, 1'b0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_ready", in_ready_o, 1);
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid_o) nv++;
      @(negedge clk);
      #1;
    end
    chk("flush_no_out", nv, 0);
    @(negedge clk);

    send(5'd16, 2'b00, 32'h0, 32'd3, 32'd4, 32'd0, 1'b0, 3'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstb_ready", in_ready_o, 1);
    chk("rstb_res", alu_result_o, 0);
    chk("rstb_pc4", pc_plus4_o, 0);
    chk("rstb_npc", new_pc_o, 0);
    nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid_o) nv++;
      @(negedge clk);
      #1;
    end
    chk("rstb_no_out", nv, 0);
    @(negedge clk);

    send(5'd8, 2'b00, 32'h200, 32'h0F0, 32'h00F, 32'd0, 1'b0, 3'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
Registered, parametrised execute stage for the RV32/RV64 core. It takes decoded operands from ID through a valid/ready handshake, computes the ALU result, branch decision and target PC, and presents them to MEM from a one-entry output register. Optional iterative multiply/divide (M subset) runs through a busy FSM that stalls upstream. A flush input kills in-flight work on redirect.

Parameters:
XLEN, 32, datapath width (32 or 64)
MULDIV_EN, 1, 1 = MUL/DIV/DIVU/REM/REMU supported; 0 = those ops return 0 with illegal_o=1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush_i  in  1  kill pending/busy op and output entry
in_valid_i  in  1  ID presents an op
in_ready_o  out  1  stage accepts op this cycle
pc_i  in  XLEN  instruction PC
rs1_i  in  XLEN  operand rs1
rs2_i  in  XLEN  operand rs2
imm_i  in  XLEN  sign-extended immediate
alu_op_i  in  5  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB,16 MUL,17 DIV,18 DIVU,19 REM,20 REMU; others illegal
data_origin_i  in  2  bit0: A=pc else rs1; bit1: B=imm else rs2
br_sig_i  in  1  branch/jump instruction
br_op_i  in  3  000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU,010 JAL,011 JALR
out_valid_o  out  1  output entry valid
out_ready_i  in  1  MEM consumes entry
alu_result_o  out  XLEN  result
pc_plus4_o  out  XLEN  pc_i+4
new_pc_o  out  XLEN  next PC
br_taken_o  out  1  redirect required
illegal_o  out  1  unsupported alu_op

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, out_valid_o=0, all data outputs 0, in_ready_o=0 in reset cycle.
- Handshake: transfer on in_valid_i&in_ready_o; out consumed on out_valid_o&out_ready_i. in_ready_o = (state==IDLE) & (!out_valid_o | out_ready_i) & !flush_i. Output entry holds stable while out_valid_o&!out_ready_i.
- Single-cycle ops (0..10): latency 1; results registered on accept edge, out_valid_o=1 next cycle. Back-to-back throughput 1/cycle when out_ready_i=1.
- Shifts use B[log2(XLEN)-1:0]. SLT/SLTU return 1/0 zero-extended. Arithmetic wraps modulo 2^XLEN.
- Branch compare always on rs1_i vs rs2_i (independent of data_origin). Taken = condition true, or JAL/JALR. new_pc_o = JALR ? (ALU ADD result & ~1) : taken ? pc+imm : pc+4. br_taken_o only when br_sig_i=1.
- FSM (MULDIV_EN=1): IDLE -> BUSY on accept of op 16..20; BUSY runs exactly XLEN cycles (shift-add multiply, restoring divide, one bit/cycle, signed ops on magnitudes with sign fix-up); BUSY -> DONE writes output entry, out_valid_o=1 on cycle XLEN+1 after accept; DONE -> IDLE same cycle (DONE is the write cycle). in_ready_o=0 throughout BUSY.
- MUL returns low XLEN bits. Divide by zero: DIV/DIVU quotient all-ones, REM/REMU = dividend. Signed overflow (MIN/-1): DIV=MIN, REM=0. Special cases computed still take full XLEN cycles (fixed latency).
- MULDIV_EN=0 or illegal op: latency 1, alu_result_o=0, illegal_o=1, br_taken_o=0.
- flush_i (highest priority below reset): out_valid_o<=0, state<=IDLE, iterative op discarded; no accept in that cycle.
- Simultaneous consume and accept: entry replaced next cycle, out_valid_o stays 1.
- Reset mid-BUSY: returns to IDLE, no output produced.

Test Plan:
- Reset then ADD rs1=5,rs2=7,data_origin=00 -> next cycle out_valid_o=1, alu_result_o=12, pc_plus4_o=pc+4, br_taken_o=0.
- BLT pc=0x100, imm=0x20, rs1=0xFFFFFFFF, rs2=1 -> br_taken_o=1, new_pc_o=0x120; same with BLTU -> taken=0, new_pc_o=0x104.
- JALR rs1=0x203, imm=4, data_origin=10 -> new_pc_o=0x206, br_taken_o=1.
- DIV rs1=-7, rs2=2 (XLEN=32) -> in_ready_o=0 for 32 cycles, out_valid_o at cycle 33, result 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU by 0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
- Backpressure: out_ready_i=0 with 3 ops queued -> output holds first result, in_ready_o=0; release -> 3 results in order, one per cycle.
- flush_i asserted at BUSY cycle 10 of MUL 3*4 -> no out_valid_o, in_ready_o=1 next cycle; repeat with rst_n=0 mid-BUSY -> same, all outputs 0.
